// File: rtl/uart_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_calc_pkg
// Description : Shared types and constants for the UART calculator datapath
//               (operand assembler, top controller, adder).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_calc_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        COLLECT_A = 2'd0,
        COLLECT_B = 2'd1,
        HOLD      = 2'd2
    } opasm_state_t;

endpackage : uart_calc_pkg
`default_nettype wire

// File: rtl/uart_opasm_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_opasm_timeout
// Description : Inter-byte idle counter. Counts enabled, uncleared cycles and
//               raises expire_o in the cycle whose edge would bring the count
//               to TIMEOUT_CYCLES-1. A clear in that same cycle suppresses it.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_opasm_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is the edge that reaches the terminal count; a clear (byte taken) wins
    assign expire_o = en_i & ~clr_i & (cnt_q == CNT_LAST);

    // Next count: restart on clear or expiry, advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_opasm_timeout
`default_nettype wire

// File: rtl/uart_operand_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_operand_assembler
// Description : Collects 2*OP_BYTES bytes (MSB first) from the UART byte
//               stream and presents them as operands A and B on a valid/ready
//               handshake. Optional inter-byte timeout, enabled by defining
//               UART_OPASM_TIMEOUT_EN, discards a stalled partial frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_operand_assembler
    import uart_calc_pkg::*;
#(
    parameter int OP_BYTES       = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BYTE_W-1:0]          s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [BYTE_W*OP_BYTES-1:0] m_op_a,
    output logic [BYTE_W*OP_BYTES-1:0] m_op_b,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       frame_err,
    output logic [2:0]                 byte_idx
);

    localparam int         OP_W       = BYTE_W * OP_BYTES;
    localparam logic [2:0] LAST_A_IDX = 3'(OP_BYTES - 1);
    localparam logic [2:0] LAST_B_IDX = 3'(2 * OP_BYTES - 1);

    // Out-of-range settings elaborate this empty marker scope so they are easy to spot
    if (OP_BYTES < 1 || OP_BYTES > 4 || TIMEOUT_CYCLES < 2) begin : g_illegal_params
    end

    opasm_state_t    state_q,    state_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [OP_W-1:0] op_a_q,     op_a_d;
    logic [OP_W-1:0] op_b_q,     op_b_d;
    logic            valid_q,    valid_d;
    logic            tready_q,   tready_d;

    logic            w_accept;
    logic            w_expire;
    logic [OP_W-1:0] w_shift_a;
    logic [OP_W-1:0] w_shift_b;

    assign w_accept = s_axis_tvalid & tready_q;

    // Operand shift-in: a single-byte operand is simply replaced
    if (OP_BYTES == 1) begin : g_shift_single
        assign w_shift_a = s_axis_tdata;
        assign w_shift_b = s_axis_tdata;
    end else begin : g_shift_multi
        assign w_shift_a = {op_a_q[OP_W-BYTE_W-1:0], s_axis_tdata};
        assign w_shift_b = {op_b_q[OP_W-BYTE_W-1:0], s_axis_tdata};
    end

`ifdef UART_OPASM_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_en;
    logic frame_err_q;

    // Counter only runs while a frame is partially received
    assign w_to_clr = w_accept | (byte_idx_q == 3'd0) | (state_q == HOLD);
    assign w_to_en  = (state_q != HOLD);

    uart_opasm_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_to_clr),
        .en_i     (w_to_en),
        .expire_o (w_expire)
    );

    // One-cycle discard indication, registered off the expiry strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= w_expire;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign w_expire  = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Frame sequencing: next state, byte counter and operand shifting
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        valid_d    = valid_q;
        case (state_q)
            COLLECT_A: begin
                if (w_accept) begin
                    op_a_d     = w_shift_a;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == LAST_A_IDX) begin
                        state_d = COLLECT_B;
                    end
                end else if (w_expire) begin
                    state_d    = COLLECT_A;
                    byte_idx_d = 3'd0;
                end
            end
            COLLECT_B: begin
                if (w_accept) begin
                    op_b_d = w_shift_b;
                    if (byte_idx_q == LAST_B_IDX) begin
                        state_d    = HOLD;
                        byte_idx_d = 3'd0;
                        valid_d    = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end else if (w_expire) begin
                    state_d    = COLLECT_A;
                    byte_idx_d = 3'd0;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = COLLECT_A;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = COLLECT_A;
                byte_idx_d = 3'd0;
                valid_d    = 1'b0;
            end
        endcase
        // Ready follows the next state so it can never overlap m_valid
        tready_d = (state_d != HOLD);
    end

    // Registered FSM state and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT_A;
            byte_idx_q <= 3'd0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            valid_q    <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            valid_q    <= valid_d;
            tready_q   <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_op_a        = op_a_q;
    assign m_op_b        = op_b_q;
    assign m_valid       = valid_q;
    assign byte_idx      = byte_idx_q;

endmodule : uart_operand_assembler
`default_nettype wire

// File: tb/tb_uart_operand_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_operand_assembler
// Description : Self-checking bench for uart_operand_assembler (OP_BYTES=2,
//               TIMEOUT_CYCLES=16). Timeout scenarios run when
//               UART_OPASM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_operand_assembler;

    localparam int OP_BYTES       = 2;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [7:0]  tdata  = 8'h00;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        frame_err;
    logic [2:0]  byte_idx;

    int test_cnt  = 0;
    int fail_cnt  = 0;
    int fe_cycles = 0;

    // Reference model: bytes accepted in the current frame, and last presented pair
    logic [7:0]  sent_q[$];
    logic [15:0] exp_a = 16'h0000;
    logic [15:0] exp_b = 16'h0000;

    uart_operand_assembler #(
        .OP_BYTES       (OP_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .m_op_a        (op_a),
        .m_op_b        (op_b),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .frame_err     (frame_err),
        .byte_idx      (byte_idx)
    );

    always #5 clk = ~clk;

    // Count cycles with frame_err high, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte after 'gap' idle edges and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
        tdata  = b;
        tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (tready === 1'b1) begin
                @(posedge clk);
                #1;
                tvalid = 1'b0;
                done   = 1'b1;
            end
        end
        if (done) begin
            sent_q.push_back(b);
        end else begin
            tvalid = 1'b0;
            check("accept_bound", 32'd0, 32'd1);
        end
    endtask

    // Expected operands come straight from the accepted-byte order
    task automatic check_ops(input string tag);
        if (sent_q.size() != 4) begin
            check({tag, "_bytes"}, sent_q.size(), 4);
        end else begin
            exp_a = {sent_q[0], sent_q[1]};
            exp_b = {sent_q[2], sent_q[3]};
            check({tag, "_valid"}, m_valid, 1);
            check({tag, "_op_a"}, op_a, exp_a);
            check({tag, "_op_b"}, op_b, exp_b);
            check({tag, "_tready"}, tready, 0);
        end
        sent_q.delete();
    endtask

    task automatic send_frame(input string tag, input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(w >> (8 * (3 - i))), int'($urandom_range(maxgap, 0)));
            check({tag, "_idx"}, byte_idx, (i + 1) % 4);
            if (i < 3) check({tag, "_early_valid"}, m_valid, 0);
        end
        check_ops(tag);
    endtask

    // Complete the handshake; the pair is retained after m_valid drops
    task automatic handshake(input string tag);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hs_valid"}, m_valid, 0);
        check({tag, "_hs_tready"}, tready, 1);
        check({tag, "_hs_op_a"}, op_a, exp_a);
        check({tag, "_hs_op_b"}, op_b, exp_b);
    endtask

    initial begin
        int fe_before;
        int maxgap;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_tready", tready, 0);
        check("rst_idx", byte_idx, 0);
        check("rst_ferr", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_tready_low", tready, 0);
        @(posedge clk);
        #1;
        check("rel_tready_high", tready, 1);

        // Basic frame, downstream always ready: m_valid lasts one cycle
        m_ready = 1'b1;
        send_frame("t1", 32'h12345678, 0);
        check("t1_a_const", exp_a, 16'h1234);
        check("t1_b_const", exp_b, 16'h5678);
        handshake("t1");

        // Back-pressure: pair held, next byte stalls until after the handshake
        m_ready = 1'b0;
        send_frame("t2", 32'h12345678, 2);
        tdata  = 8'h9A;
        tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("t2_hold_valid", m_valid, 1);
            check("t2_hold_op_a", op_a, 16'h1234);
            check("t2_hold_op_b", op_b, 16'h5678);
            check("t2_hold_tready", tready, 0);
            check("t2_hold_idx", byte_idx, 0);
        end
        handshake("t2");
        check("t2_stall_idx", byte_idx, 0);
        send_frame("t2b", 32'h9ABCDEF0, 0);
        check("t2b_op_a_abs", op_a, 16'h9ABC);
        check("t2b_op_b_abs", op_b, 16'hDEF0);
        handshake("t2b");

        // Asynchronous reset mid-frame clears outputs without a clock edge
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        check("t5_pre_idx", byte_idx, 3);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_op_a", op_a, 0);
        check("t5_async_op_b", op_b, 0);
        check("t5_async_valid", m_valid, 0);
        check("t5_async_tready", tready, 0);
        check("t5_async_idx", byte_idx, 0);
        check("t5_async_ferr", frame_err, 0);
        sent_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rel_tready", tready, 0);
        @(posedge clk);
        #1;
        check("t5_rel_tready_high", tready, 1);
        send_frame("t5", 32'h11223344, 0);
        handshake("t5");

`ifdef UART_OPASM_TIMEOUT_EN
        // Partial frame then idle: one discard pulse on the 15th idle edge
        fe_before = fe_cycles;
        send_byte(8'hAA, 0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("t3_ferr_idle%0d", k), frame_err, (k == TIMEOUT_CYCLES - 1) ? 1 : 0);
            if (k >= TIMEOUT_CYCLES - 1) check($sformatf("t3_idx_idle%0d", k), byte_idx, 0);
        end
        check("t3_pulse_count", fe_cycles - fe_before, 1);
        check("t3_no_valid", m_valid, 0);
        sent_q.delete();
        send_frame("t3", 32'h01020304, 0);
        handshake("t3");

        // Byte arriving on the terminal edge is taken and no discard happens
        fe_before = fe_cycles;
        send_byte(8'h55, 0);
        send_byte(8'h66, TIMEOUT_CYCLES - 2);
        check("t4_idx", byte_idx, 2);
        check("t4_ferr", frame_err, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        check_ops("t4");
        handshake("t4");
        check("t4_pulse_count", fe_cycles - fe_before, 0);
        maxgap = TIMEOUT_CYCLES - 6;
`else
        fe_before = 0;
        maxgap    = 50;
`endif

        // Randomized frames with random byte gaps and random downstream stalls
        fe_before = fe_cycles;
        for (int f = 0; f < 6; f++) begin
            logic [31:0] w;
            int          stall;
            w       = $urandom;
            stall   = int'($urandom_range(5, 0));
            m_ready = (stall == 0);
            send_frame($sformatf("t6_f%0d", f), w, maxgap);
            check($sformatf("t6_f%0d_a_word", f), exp_a, w[31:16]);
            check($sformatf("t6_f%0d_b_word", f), exp_b, w[15:0]);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("t6_f%0d_stall_valid", f), m_valid, 1);
            end
            handshake($sformatf("t6_f%0d", f));
        end
        check("t6_no_ferr", fe_cycles - fe_before, 0);

`ifndef UART_OPASM_TIMEOUT_EN
        check("total_no_ferr", fe_cycles, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_uart_operand_assembler
`default_nettype wire
